// File: rtl/renkon_pool_stream_if.sv
// Stream port bundle for renkon_pool_stream: window config, input beats and pooled results.
interface renkon_pool_stream_if #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 4,
    parameter int CWIDTH = 5,
    parameter int SWIDTH = 4
);
    logic                      clear;
    logic                      mode;
    logic [CWIDTH-1:0]         win_len;
    logic [SWIDTH-1:0]         avg_shift;
    logic                      in_valid;
    logic [LANES*DWIDTH-1:0]   pixel_in;
    logic                      out_valid;
    logic [LANES*DWIDTH-1:0]   pixel_out;
    logic                      busy;

    modport master (
        output clear, mode, win_len, avg_shift, in_valid, pixel_in,
        input  out_valid, pixel_out, busy
    );

    modport slave (
        input  clear, mode, win_len, avg_shift, in_valid, pixel_in,
        output out_valid, pixel_out, busy
    );
endinterface

// File: rtl/renkon_pool_stream.sv
// Multi-lane streaming window pooler: signed max or shifted/saturated average over
// 1..MAXWIN elements, three-stage pipeline (input reg, accumulate, result reg).
module renkon_pool_lane #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 5,
    parameter int SWIDTH = 4
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              acc_en,
    input  logic              first,
    input  logic              mode,
    input  logic [DWIDTH-1:0] px,
    input  logic              res_en,
    input  logic              res_mode,
    input  logic [SWIDTH-1:0] res_shift,
    output logic [DWIDTH-1:0] res_q
);
    localparam int AW = DWIDTH + CWIDTH;
    localparam logic signed [AW-1:0] MAXV = {{(CWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(CWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic [AW-1:0]        acc_q, acc_d, pxe;
    logic signed [AW-1:0] shifted;
    logic [DWIDTH-1:0]    sat, res_d;

    always_comb begin
        pxe     = {{CWIDTH{px[DWIDTH-1]}}, px};
        shifted = $signed(acc_q) >>> res_shift;
        if (shifted > MAXV)      sat = MAXV[DWIDTH-1:0];
        else if (shifted < MINV) sat = MINV[DWIDTH-1:0];
        else                     sat = shifted[DWIDTH-1:0];

        // First element reloads, so negative-only windows need no seed value.
        acc_d = acc_q;
        if (acc_en) begin
            if (first)                              acc_d = pxe;
            else if (mode)                          acc_d = acc_q + pxe;
            else if ($signed(pxe) > $signed(acc_q)) acc_d = pxe;
        end

        res_d = res_q;
        if (res_en) res_d = res_mode ? sat : acc_q[DWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end
endmodule

module renkon_pool_stream #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 4,
    parameter int MAXWIN = 16,
    parameter int CWIDTH = 5,
    parameter int SWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 xrst,
    renkon_pool_stream_if.slave  bus
);
    logic [CWIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cur_len;
    logic              mode_q, mode_d;
    logic [SWIDTH-1:0] shift_q, shift_d;
    logic              is_first, is_last;

    // [0] stage-1 valid, [1] stage-2 valid, [2] out_valid
    logic [2:0] vld_pipe_q, vld_pipe_d;

    logic [LANES-1:0][DWIDTH-1:0] px_q, px_d, res;
    logic              s1_first_q, s1_first_d, s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
    logic [SWIDTH-1:0] s1_shift_q, s1_shift_d, s2_shift_q, s2_shift_d;
    logic              s2_last_q, s2_last_d, s2_mode_q, s2_mode_d;
    logic              res_en;

    assign is_first = (cnt_q == '0);
    assign cur_len  = !is_first ? len_q : ((bus.win_len == '0) ? CWIDTH'(1) : bus.win_len);
    assign is_last  = (cnt_q == cur_len - CWIDTH'(1));
    assign res_en   = vld_pipe_q[1] & s2_last_q & ~bus.clear;

    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        mode_d     = mode_q;
        shift_d    = shift_q;
        px_d       = px_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_mode_d  = s1_mode_q;
        s1_shift_d = s1_shift_q;
        s2_last_d  = s2_last_q;
        s2_mode_d  = s2_mode_q;
        s2_shift_d = s2_shift_q;

        if (bus.clear) begin
            cnt_d = '0;
        end else if (bus.in_valid) begin
            cnt_d = is_last ? '0 : cnt_q + CWIDTH'(1);
            if (is_first) begin
                len_d   = cur_len;
                mode_d  = bus.mode;
                shift_d = bus.avg_shift;
            end
            // Config rides with each beat so a following window can't disturb it.
            px_d       = bus.pixel_in;
            s1_first_d = is_first;
            s1_last_d  = is_last;
            s1_mode_d  = is_first ? bus.mode : mode_q;
            s1_shift_d = is_first ? bus.avg_shift : shift_q;
        end

        if (vld_pipe_q[0]) begin
            s2_last_d  = s1_last_q;
            s2_mode_d  = s1_mode_q;
            s2_shift_d = s1_shift_q;
        end

        vld_pipe_d = bus.clear ? 3'b000 :
                     {vld_pipe_q[1] & s2_last_q, vld_pipe_q[0], bus.in_valid};
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cnt_q      <= '0;
            len_q      <= '0;
            mode_q     <= 1'b0;
            shift_q    <= '0;
            vld_pipe_q <= '0;
            px_q       <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_shift_q <= '0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_shift_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            shift_q    <= shift_d;
            vld_pipe_q <= vld_pipe_d;
            px_q       <= px_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s1_shift_q <= s1_shift_d;
            s2_last_q  <= s2_last_d;
            s2_mode_q  <= s2_mode_d;
            s2_shift_q <= s2_shift_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        renkon_pool_lane #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH)) u_lane (
            .clk       (clk),
            .xrst      (xrst),
            .acc_en    (vld_pipe_q[0]),
            .first     (s1_first_q),
            .mode      (s1_mode_q),
            .px        (px_q[k]),
            .res_en    (res_en),
            .res_mode  (s2_mode_q),
            .res_shift (s2_shift_q),
            .res_q     (res[k])
        );
    end

    assign bus.pixel_out = res;
    assign bus.out_valid = vld_pipe_q[2];
    assign bus.busy      = (cnt_q != '0) | vld_pipe_q[0] | vld_pipe_q[1];
endmodule

// File: tb/tb_renkon_pool_stream.sv
// Directed bench for renkon_pool_stream: max/avg windows, saturation, back-to-back,
// mid-stream win_len change, clear and asynchronous reset.
module tb_renkon_pool_stream;
    localparam int DW = 16;
    localparam int LN = 4;

    logic clk = 1'b0;
    logic xrst;
    int   checks = 0;
    int   failures = 0;
    int   ov_cnt = 0;
    int   base;

    renkon_pool_stream_if #(.DWIDTH(DW), .LANES(LN), .CWIDTH(5), .SWIDTH(4)) bus ();

    renkon_pool_stream #(.DWIDTH(DW), .LANES(LN), .MAXWIN(16), .CWIDTH(5), .SWIDTH(4)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.out_valid === 1'b1) ov_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [DW-1:0] lane(input int k);
        return bus.pixel_out[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic signed [DW-1:0] a, b, c, d);
        bus.in_valid = 1'b1;
        bus.pixel_in = {d, c, b, a};
        tick();
        bus.in_valid = 1'b0;
    endtask

    int vals [5] = '{1, 5, 7, 2, 8};
    int wl   [5] = '{2, 3, 3, 2, 2};

    initial begin
        xrst = 1'b0;
        bus.clear = 1'b0; bus.mode = 1'b0; bus.win_len = '0; bus.avg_shift = '0;
        bus.in_valid = 1'b0; bus.pixel_in = '0;
        tick(); tick();
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_px0", lane(0), 0);
        chk("rst_px3", lane(3), 0);
        chk("rst_busy", bus.busy, 0);
        xrst = 1'b1;
        tick();

        // max, win_len=4
        bus.mode = 1'b0; bus.win_len = 5'd4;
        beat(3, -100, -1, 0);
        chk("max_busy", bus.busy, 1);
        beat(-7, -2, -1, 1);
        beat(12, -50, -1, 2);
        beat(5, -9, -1, 3);
        tick();
        chk("max_early", bus.out_valid, 0);
        tick();
        chk("max_ov", bus.out_valid, 1);
        chk("max_l0", lane(0), 12);
        chk("max_l1", lane(1), -2);
        chk("max_l2", lane(2), -1);
        chk("max_l3", lane(3), 3);
        chk("max_idle_busy", bus.busy, 0);
        tick();
        chk("max_pulse", bus.out_valid, 0);
        chk("max_hold", lane(0), 12);

        // avg, win_len=4, shift 2
        bus.mode = 1'b1; bus.avg_shift = 4'd2;
        beat(1, -1, 0, 0); beat(2, -2, 0, 0); beat(3, -3, 0, 0); beat(6, -4, 0, 0);
        tick(); tick();
        chk("avg_ov", bus.out_valid, 1);
        chk("avg_l0", lane(0), 3);
        chk("avg_l1_floor", lane(1), -3);

        bus.win_len = 5'd2; bus.avg_shift = 4'd1;
        beat(-1, 0, 0, 0); beat(-2, 0, 0, 0);
        tick(); tick();
        chk("avg2_ov", bus.out_valid, 1);
        chk("avg2_floor", lane(0), -2);

        // saturation
        bus.win_len = 5'd4; bus.avg_shift = 4'd0;
        beat(32767, -32768, 100, 0); beat(32767, -32768, 200, 0);
        beat(32767, -32768, -50, 0); beat(32767, -32768, 0, 0);
        tick(); tick();
        chk("sat_ov", bus.out_valid, 1);
        chk("sat_hi", lane(0), 32767);
        chk("sat_lo", lane(1), -32768);
        chk("sat_mid", lane(2), 250);
        tick();

        // back-to-back, win_len=1
        bus.mode = 1'b0; bus.win_len = 5'd1;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                bus.in_valid = 1'b1;
                bus.pixel_in = {48'd0, 16'(j)};
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (j >= 2) begin
                chk("b2b_ov", bus.out_valid, 1);
                chk("b2b_val", lane(0), j - 2);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_end", bus.out_valid, 0);

        // win_len change applies only at the next window boundary
        for (int j = 0; j < 8; j++) begin
            if (j < 5) begin
                bus.in_valid = 1'b1;
                bus.win_len  = 5'(wl[j]);
                bus.pixel_in = {48'd0, 16'(vals[j])};
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            chk("wl_ov", bus.out_valid, (j == 3 || j == 6) ? 1 : 0);
            if (j == 3) chk("wl_win1", lane(0), 5);
            if (j == 6) chk("wl_win2", lane(0), 8);
        end
        bus.in_valid = 1'b0;

        // clear after 2 of 4 beats
        bus.win_len = 5'd4;
        beat(100, 0, 0, 0); beat(50, 0, 0, 0);
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.pixel_in = {48'd0, 16'd77};
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        chk("clr_busy", bus.busy, 0);
        chk("clr_ov", bus.out_valid, 0);
        chk("clr_hold", lane(0), 8);
        base = ov_cnt;
        beat(9, 0, 0, 0); beat(1, 0, 0, 0); beat(1, 0, 0, 0); beat(1, 0, 0, 0);
        tick(); tick(); tick();
        chk("clr_pulses", ov_cnt - base, 1);
        chk("clr_val", lane(0), 9);

        // clear drops a result already in flight
        bus.win_len = 5'd1;
        base = ov_cnt;
        beat(33, 0, 0, 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick(); tick();
        chk("clr_inflight", ov_cnt - base, 0);
        chk("clr_inflight_hold", lane(0), 9);

        // asynchronous reset mid-window
        bus.win_len = 5'd4;
        beat(-5, 0, 0, 0); beat(-3, 0, 0, 0);
        #2 xrst = 1'b0;
        #1;
        chk("arst_ov", bus.out_valid, 0);
        chk("arst_px", lane(0), 0);
        chk("arst_busy", bus.busy, 0);
        tick();
        xrst = 1'b1;
        base = ov_cnt;
        beat(-5, 7, 0, 0); beat(-3, 8, 0, 0); beat(-8, 9, 0, 0); beat(-4, 10, 0, 0);
        tick(); tick();
        chk("post_rst_ov", bus.out_valid, 1);
        chk("post_rst_l0", lane(0), -3);
        chk("post_rst_l1", lane(1), 10);

        // win_len=0 behaves as 1
        bus.win_len = 5'd0;
        beat(42, 0, 0, 0); beat(43, 0, 0, 0);
        tick();
        chk("wl0_ov_a", bus.out_valid, 1);
        chk("wl0_a", lane(0), 42);
        tick();
        chk("wl0_ov_b", bus.out_valid, 1);
        chk("wl0_b", lane(0), 43);
        tick();
        chk("wl0_end", bus.out_valid, 0);
        chk("post_rst_pulses", ov_cnt - base, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
